// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath and memory-hierarchy types.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef enum logic {ARB_I, ARB_D} lc3b_arb_owner;
endpackage

// File: rtl/l1_l2_arbiter_control.sv
// l1_l2_arbiter_control: grant FSM with round-robin tie-break between the L1 sides.
module l1_l2_arbiter_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic l2_resp,
  output logic grant_i,
  output logic grant_d,
  output logic capture,
  output logic serve_i,
  output logic serve_d
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t        state_q, state_d;
  lc3b_arb_owner last_grant_q, last_grant_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  // D wins a tie only when I was the last side served.
  always_comb begin
    serve_i      = state_q == SERVE_I;
    serve_d      = state_q == SERVE_D;
    grant_d      = state_q == IDLE && d_req && (!i_req || last_grant_q == ARB_I);
    grant_i      = state_q == IDLE && i_req && !grant_d;
    state_d      = grant_d ? SERVE_D : grant_i ? SERVE_I : state_q;
    last_grant_d = last_grant_q;
    if ((serve_i || serve_d) && l2_resp) begin
      state_d      = IDLE;
      last_grant_d = serve_i ? ARB_I : ARB_D;
    end
  end
  assign capture = grant_i | grant_d;
endmodule

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: serialises I/D L1 line requests onto the single L2 port.
module l1_l2_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output lc3b_cacheline i_rdata,
  output logic          i_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_cacheline d_wdata,
  output lc3b_cacheline d_rdata,
  output logic          d_resp,
  output logic          l2_read,
  output logic          l2_write,
  output lc3b_word      l2_address,
  output lc3b_cacheline l2_wdata,
  input  lc3b_cacheline l2_rdata,
  input  logic          l2_resp
);
  logic          grant_i, grant_d, capture, serve_i, serve_d;
  lc3b_word      addr_q, addr_d;
  lc3b_cacheline wdata_q, wdata_d;
  logic          write_q, write_d;
  l1_l2_arbiter_control u_control (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_read),
    .d_req   (d_read | d_write),
    .l2_resp (l2_resp),
    .grant_i (grant_i),
    .grant_d (grant_d),
    .capture (capture),
    .serve_i (serve_i),
    .serve_d (serve_d)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  // d_read with d_write resolves to a write.
  always_comb begin
    addr_d  = capture ? (grant_d ? d_address : i_address) : addr_q;
    write_d = capture ? (grant_d & d_write) : write_q;
    wdata_d = (grant_d && d_write) ? d_wdata : wdata_q;
  end
  assign l2_read    = (serve_i | serve_d) & ~write_q;
  assign l2_write   = (serve_i | serve_d) & write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign i_resp     = serve_i & l2_resp;
  assign d_resp     = serve_d & l2_resp;
  assign i_rdata    = l2_rdata;
  assign d_rdata    = l2_rdata;
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: directed and randomized checks against a transaction-level model.
module tb_l1_l2_arbiter;
  logic         clk = 0, reset = 0;
  logic         i_read = 0, d_read = 0, d_write = 0, l2_resp = 0;
  logic [15:0]  i_address = 0, d_address = 0, l2_address;
  logic [127:0] d_wdata = 0, l2_rdata = 0, i_rdata, d_rdata, l2_wdata;
  logic         i_resp, d_resp, l2_read, l2_write;
  int           tests = 0, fails = 0;
  bit           last_d = 0;

  l1_l2_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset) assert (!(d_read && d_write)) else begin
      fails++;
      $error("FAIL illegal_d_rw: observed d_read=1 d_write=1 expected at most one");
    end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick_d(input bit ir, input bit dr);
    return dr && (!ir || !last_d);
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset = 1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    @(negedge clk);
    chk("rst_strobes", {l2_read, l2_write, i_resp, d_resp}, 4'b0);
    chk("rst_addr", l2_address, 0);
    chk("rst_wdata", l2_wdata, 0);
    reset = 0; last_d = 0;
    @(posedge clk); #1;
  endtask

  // Entered during an IDLE cycle with requests already driven; returns in the following IDLE cycle.
  task automatic serve(input bit exp_d, input bit exp_wr, input logic [15:0] exp_addr,
                       input logic [127:0] exp_wdata, input int lat, input bit wig,
                       input logic [15:0] new_addr);
    logic [127:0] rd;
    @(negedge clk);
    chk("idle_strobes", {l2_read, l2_write}, 2'b0);
    @(posedge clk); #1;
    if (wig) begin
      if (exp_d) d_address = new_addr; else i_address = new_addr;
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("strobe", {l2_read, l2_write}, {!exp_wr, exp_wr});
      chk("address", l2_address, exp_addr);
      if (exp_wr) chk("wdata", l2_wdata, exp_wdata);
      chk("early_resp", {i_resp, d_resp}, 2'b0);
      @(posedge clk); #1;
    end
    rd = rnd_line();
    l2_rdata = rd; l2_resp = 1;
    @(negedge clk);
    chk("resp_strobe", {l2_read, l2_write}, {!exp_wr, exp_wr});
    chk("resp_addr", l2_address, exp_addr);
    chk("resp", {i_resp, d_resp}, {!exp_d, exp_d});
    chk("rdata", exp_d ? d_rdata : i_rdata, rd);
    @(posedge clk); #1;
    l2_resp = 0; last_d = exp_d;
  endtask

  initial begin
    bit ip, dp, dw, own;
    logic [15:0] ia, da;
    logic [127:0] dwd;
    reset = 1; #2;
    do_reset();

    i_read = 1; i_address = 16'h1230;
    serve(0, 0, 16'h1230, 0, 2, 0, 0);
    i_read = 0;

    d_write = 1; d_address = 16'h8040; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    serve(1, 1, 16'h8040, 128'h0123456789ABCDEF0123456789ABCDEF, 3, 0, 0);
    d_write = 0;

    do_reset();
    i_read = 1; d_read = 1;
    for (int n = 0; n < 4; n++) begin
      i_address = 16'($urandom); d_address = 16'($urandom);
      own = pick_d(1, 1);
      chk("tie_order", own, n % 2 == 0);
      serve(own, 0, own ? d_address : i_address, 0, 1 + n, 0, 0);
    end
    i_read = 0; d_read = 0;

    d_read = 1; d_address = 16'h8040;
    serve(1, 0, 16'h8040, 0, 3, 1, 16'hFFF0);
    d_read = 0;

    i_read = 1; i_address = 16'h4440;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_read", l2_read, 1);
    #2 reset = 1;
    #1 chk("async_drop", {l2_read, l2_write}, 2'b0);
    i_read = 0; last_d = 0;
    @(posedge clk); #3 reset = 0;
    @(negedge clk);
    chk("post_reset_idle", {l2_read, l2_write, i_resp, d_resp}, 4'b0);
    @(posedge clk); #1;
    i_read = 1; i_address = 16'h0ABC;
    serve(0, 0, 16'h0ABC, 0, 1, 0, 0);
    i_read = 0;

    l2_resp = 1; l2_rdata = rnd_line();
    @(negedge clk);
    chk("spurious_resp", {i_resp, d_resp}, 2'b0);
    @(posedge clk); #1 l2_resp = 0;
    @(negedge clk);
    chk("spurious_state", {l2_read, l2_write}, 2'b0);
    @(posedge clk); #1;

    ip = 0; dp = 0; dw = 0; ia = 0; da = 0; dwd = 0;
    for (int n = 0; n < 30; n++) begin
      if (!ip) begin ip = 1'($urandom); ia = 16'($urandom); end
      if (!dp) begin dp = 1'($urandom); dw = 1'($urandom); da = 16'($urandom); dwd = rnd_line(); end
      if (!ip && !dp) begin ip = 1; ia = 16'($urandom); end
      i_read = ip; i_address = ia;
      d_read = dp && !dw; d_write = dp && dw; d_address = da; d_wdata = dwd;
      own = pick_d(ip, dp);
      serve(own, own && dw, own ? da : ia, dwd, $urandom_range(0, 4), 1'($urandom), 16'($urandom));
      if (own) begin dp = 0; d_read = 0; d_write = 0; end
      else begin ip = 0; i_read = 0; end
    end
    i_read = 0; d_read = 0; d_write = 0;
    @(negedge clk);
    chk("final_idle", {l2_read, l2_write, i_resp, d_resp}, 4'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/l1_l2_arbiter.md
# l1_l2_arbiter

Two-port arbiter between the split L1 caches (instruction and data) and the shared unified L2 cache. Accepts cacheline-granularity miss and writeback requests from both L1s, serialises them onto the single L2 request port, and returns the L2 response to the requester that owns the transaction. Tied requests alternate round-robin.

## Interface
- No parameters. Widths come from lc3b_types: lc3b_word is 16 bits and lc3b_cacheline is 128 bits.
- clk  in  1  Sole clock; all state updates on its rising edge.
- reset  in  1  Asynchronous, active-high reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  16  I-cache line address (lc3b_word).
- i_rdata  out  128  Line returned to the I-cache.
- i_resp  out  1  One-cycle completion strobe to the I-cache.
- d_read / d_write  in  1 each  D-cache line read or writeback request; held until d_resp.
- d_address  in  16  D-cache line address.
- d_wdata  in  128  D-cache writeback line.
- d_rdata  out  128  Line returned to the D-cache.
- d_resp  out  1  One-cycle completion strobe to the D-cache.
- l2_read / l2_write  out  1 each  Request to L2; held until l2_resp.
- l2_address  out  16  Captured request address.
- l2_wdata  out  128  Captured writeback line.
- l2_rdata  in  128  L2 read line.
- l2_resp  in  1  L2 completion strobe.

## Operation
The FSM has three states: IDLE, SERVE_I, SERVE_D. A last_grant register records which requester was served last.

**IDLE**
- A requester is pending when i_read is high (I side) or when d_read or d_write is high (D side).
- Only one requester pending: go to its SERVE state.
- Both pending: grant the one not recorded in last_grant.
- On the grant edge, capture into internal registers:
  - address;
  - wdata (D writes only);
  - op: read or write.

**SERVE_x**
- Drive l2_read or l2_write, l2_address and l2_wdata from the captured registers only. The L1 inputs are ignored while in SERVE.
- When l2_resp is high:
  - drive x_resp = 1 combinationally in the same cycle;
  - pass l2_rdata through to x_rdata;
  - on the next edge, go to IDLE and set last_grant = x.
- l2_resp is ignored in IDLE.

**Output rules**
- The response of the requester that is not being served stays 0.
- i_rdata and d_rdata pass l2_rdata through unconditionally. They are only meaningful while the matching resp is high.

**Illegal input: d_read and d_write both high**
- Treat it as a write.
- The bench flags it with an assertion.

## Timing
- **Reset values:**
  - state = IDLE, last_grant = I (so D wins the first tie);
  - captured registers = 0;
  - l2_read = l2_write = i_resp = d_resp = 0.
- **Reset during SERVE:** l2_read and l2_write drop asynchronously. The L1s restart their requests after reset.
- **Request to L2:** a request sampled at edge N drives the L2 strobe from cycle N+1. Arbitration latency is 1 cycle.
- **Completion:** l2_resp in cycle M gives x_resp in cycle M. The state is IDLE in cycle M+1.
- **Back-to-back:** there is always one IDLE cycle between transactions. This lets the L1 drop its request after resp before it is sampled again.
- **No starvation:** with both sides requesting continuously, grants alternate I, D, I, D…
- **Request drop:** an L1 that drops its request while in SERVE still completes. The response is still issued.
- **Fixed L2 strobes:** the L2 strobes never change mid-transaction, even if the L1 address changes.

## Structure
- **lc3b_types already holds** lc3b_word and lc3b_cacheline.
- **Add to lc3b_types:** typedef enum logic {ARB_I, ARB_D} lc3b_arb_owner, used for last_grant. A future L2-to-pmem arbiter reuses it.
- **Local to the block:** the FSM state enum.
- **Sub-module l1_l2_arbiter_control:**
  - contains the FSM and last_grant;
  - outputs grant_i, grant_d, capture and serve signals.
- **Top level:** holds the capture registers and the output muxing.

## Test plan
1. **Single I read:** i_read = 1, i_address = 0x1230; L2 returns 128'hA5…A5 after 3 cycles.
   - Required: l2_read = 1 with l2_address = 0x1230 from cycle 1.
   - Required: i_resp is high for exactly one cycle, with i_rdata = A5…A5, and d_resp stays 0.
2. **D writeback:** d_write = 1, d_address = 0x8040, d_wdata = 128'h0123…CDEF.
   - Required: l2_write = 1 with matching address and wdata.
   - Required: d_resp in the l2_resp cycle; l2_read never asserts.
3. **Simultaneous requests out of reset:** i_read and d_read both high in the same cycle.
   - Required: D is served first; I is granted on the first IDLE after d_resp.
   - Required: a continuous 4-transaction run gives grants D, I, D, I.
4. **Address change mid-transaction:** during SERVE_D, change d_address from 0x8040 to 0xFFF0.
   - Required: l2_address stays 0x8040 until l2_resp.
5. **Asynchronous reset:** assert reset mid-SERVE_I, between clock edges.
   - Required: l2_read drops immediately and the state is IDLE.
   - Required: a new i_read after reset completes normally.
6. **Spurious L2 response:** l2_resp pulses while in IDLE.
   - Required: no i_resp or d_resp, and no state change.
